// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: PC, imem handshake,
// instruction register and next-PC resolution.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] retired
);

  localparam logic [31:0] PC_INIT =
    {PC_RESET[31:2], 2'b00};

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] r_retired;

  logic        w_req;
  logic        w_fetch_done;
  logic        w_retire;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_jmp_tgt;
  logic [31:0] w_next_pc;
  logic        w_take_jmp;
  logic        w_take_br;
  logic        w_take_seq;

  // r_run clears asynchronously so a reset drops
  // the request at once; it arms on the first edge
  // after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next state and the imem request output.
  always_comb begin
    w_state_nxt  = r_state;
    w_req        = 1'b0;
    w_fetch_done = 1'b0;
    w_retire     = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_req = r_run;
        if (r_run && imem_ready) begin
          w_fetch_done = 1'b1;
          w_state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (instr_ack) begin
          w_retire    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}},
                       r_instr[15:0], 2'b00};
  assign w_br_tgt   = w_pc_plus4 + w_br_off;
  assign w_jmp_tgt  = {w_pc_plus4[31:28],
                       r_instr[25:0], 2'b00};

  // Jump wins over a taken branch.
  assign w_take_jmp = jump;
  assign w_take_br  = ~jump & branch & zero;
  assign w_take_seq = ~jump & ~(branch & zero);

  // Next-PC select; the three terms are disjoint.
  always_comb begin
    w_next_pc = w_pc_plus4;
    unique case (1'b1)
      w_take_jmp: w_next_pc = w_jmp_tgt;
      w_take_br:  w_next_pc = w_br_tgt;
      w_take_seq: w_next_pc = w_pc_plus4;
      default:    w_next_pc = w_pc_plus4;
    endcase
  end

  // PC advances only when the held instr retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_pc <= PC_INIT;
    else if (w_retire) r_pc <= w_next_pc;
  end

  // Instruction register captures on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_instr <= 32'd0;
    else if (w_fetch_done) r_instr <= imem_rdata;
  end

  // Valid flag: set on capture, cleared on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_valid <= 1'b0;
    else if (w_fetch_done) r_valid <= 1'b1;
    else if (w_retire)     r_valid <= 1'b0;
  end

  // Retired instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retired <= 32'd0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign op          = r_instr[31:26];
  assign pc_plus4    = w_pc_plus4;
  assign retired     = r_retired;

endmodule
